// File: rtl/gomoku_main.sv
// Two-player 8x8 gomoku controller: key-matrix entry, board store,
// five-in-a-row detection, multiplexed bicolour LED matrix and buzzer.
module gomoku_main #(
  parameter int BEEP_LEN = 2000,
  parameter int ERR_LEN  = 4000,
  parameter int WIN_LEN  = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buzzer_clk,
  input  logic       buzzer_clk_2,
  input  logic       led_scan_clk,
  input  logic       kb_scan_clk,
  input  logic       led_flicker_clk_slow,
  input  logic       led_flicker_clk_fast,
  input  logic       sw_power,
  input  logic       btn_reset,
  input  logic       btn_ok,
  output logic       buzzer_out,
  output logic       led_red_status,
  output logic       led_green_status,
  output logic [7:0] led_row,
  output logic [7:0] led_col_red,
  output logic [7:0] led_col_green,
  input  logic [3:0] keyboard_row,
  output logic [3:0] keyboard_col
);

  typedef enum logic [2:0] {
    S_OFF = 3'd0, S_CLEAR = 3'd1, S_PLAY = 3'd2, S_CHECK = 3'd3, S_WIN = 3'd4
  } state_t;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_RED   = 2'd1;
  localparam logic [1:0] CELL_GREEN = 2'd2;

  // True when (px,py) lies on a run of five or more cells of colour col,
  // walking up to four steps each way along each of the four directions.
  function automatic logic five_check(input logic [63:0][1:0] b, input logic [2:0] px,
                                      input logic [2:0] py, input logic [1:0] col);
    int dx, dy, cnt, xx, yy;
    logic run, found;
    found = 1'b0;
    for (int d = 0; d < 4; d++) begin
      dx  = (d == 1) ? 0 : 1;
      dy  = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
      cnt = 1;
      for (int s = -1; s <= 1; s += 2) begin
        run = 1'b1;
        for (int k = 1; k <= 4; k++) begin
          xx = int'(px) + s * k * dx;
          yy = int'(py) + s * k * dy;
          if (run && xx >= 0 && xx < 8 && yy >= 0 && yy < 8 && b[6'(yy * 8 + xx)] == col)
            cnt++;
          else
            run = 1'b0;
        end
      end
      if (cnt >= 5) found = 1'b1;
      else          found = found;
    end
    return found;
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        in_s, in_q, in_p, rise_s;
  logic [3:0]        kb_row_q;
  logic [63:0][1:0]  board_q;
  logic              turn_q, winner_q, memrst_done_q;
  logic [2:0]        x_q, y_q, last_x_q, last_y_q, ry_q;
  logic              x_valid_q, y_valid_q;
  logic [5:0]        clr_q;
  logic [1:0]        kb_c_q, kb_idle_q;
  logic              kb_lock_q, tone_sel_q;
  logic [31:0]       beep_cnt_q;
  logic              buzzer_out_q, led_red_status_q, led_green_status_q;
  logic [7:0]        led_row_q, led_col_red_q, led_col_green_q;
  logic [3:0]        keyboard_col_q;

  logic              key_any_s, press_s, commit_s, occupied_s, win_s, rst_rise_s;
  logic [1:0]        key_row_s, colour_s;
  logic [7:0][1:0]   row_cells_s;
  logic [7:0]        red_bits_s, green_bits_s, col_red_s, col_green_s;
  logic              stat_red_s, stat_green_s;

  // Slow clocks and buttons, in order, for one shared edge detector.
  assign in_s = {buzzer_clk, buzzer_clk_2, led_scan_clk, kb_scan_clk,
                 led_flicker_clk_slow, led_flicker_clk_fast, btn_reset, btn_ok};
  assign rise_s     = in_q & ~in_p;
  assign rst_rise_s = rise_s[1];
  assign colour_s   = turn_q ? CELL_GREEN : CELL_RED;

  // Key decode: lowest pressed row wins; one event per key until the matrix idles.
  assign key_any_s  = ~&kb_row_q;
  assign key_row_s  = !kb_row_q[3] ? 2'd0 : (!kb_row_q[2] ? 2'd1 : (!kb_row_q[1] ? 2'd2 : 2'd3));
  assign press_s    = rise_s[4] && key_any_s && !kb_lock_q && (state_q == S_PLAY);
  assign commit_s   = rise_s[0] && x_valid_q && y_valid_q && (state_q == S_PLAY) && !rst_rise_s;
  assign occupied_s = board_q[{y_q, x_q}] != CELL_EMPTY;
  assign win_s      = five_check(board_q, last_x_q, last_y_q, colour_s);

  // Board row currently being scanned, split into per-colour column bits.
  assign row_cells_s = board_q[{ry_q, 3'b000} +: 8];
  genvar gx;
  generate
    for (gx = 0; gx < 8; gx++) begin : g_col
      assign red_bits_s[gx]   = row_cells_s[gx] == CELL_RED;
      assign green_bits_s[gx] = row_cells_s[gx] == CELL_GREEN;
    end
  endgenerate

  // Overlay the blinking cursor on the scanned row when a full selection exists.
  always_comb begin
    col_red_s   = red_bits_s;
    col_green_s = green_bits_s;
    if (state_q == S_PLAY && x_valid_q && y_valid_q && y_q == ry_q) begin
      col_red_s[x_q]   = !turn_q && in_q[3];
      col_green_s[x_q] = turn_q && in_q[3];
    end else begin
      col_red_s   = red_bits_s;
      col_green_s = green_bits_s;
    end
  end

  // Status LEDs: player to move while playing, blinking winner after a win.
  always_comb begin
    stat_red_s   = 1'b0;
    stat_green_s = 1'b0;
    case (state_q)
      S_PLAY, S_CHECK: begin
        stat_red_s   = !turn_q;
        stat_green_s = turn_q;
      end
      S_WIN: begin
        stat_red_s   = !winner_q && in_q[2];
        stat_green_s = winner_q && in_q[2];
      end
      default: begin
        stat_red_s   = 1'b0;
        stat_green_s = 1'b0;
      end
    endcase
  end

  // Next-state logic; CHECK is the one-cycle win evaluation after a placement.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:   state_d = sw_power ? S_CLEAR : S_OFF;
      S_CLEAR: state_d = (clr_q == 6'd63) ? S_PLAY : S_CLEAR;
      S_PLAY:  state_d = rst_rise_s ? S_CLEAR : ((commit_s && !occupied_s) ? S_CHECK : S_PLAY);
      S_CHECK: state_d = rst_rise_s ? S_CLEAR : (win_s ? S_WIN : S_PLAY);
      S_WIN:   state_d = rst_rise_s ? S_CLEAR : S_WIN;
      default: state_d = S_OFF;
    endcase
  end

  // Input sampling for edge detection and key-row capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q     <= 8'h00;
      in_p     <= 8'h00;
      kb_row_q <= 4'hF;
    end else begin
      in_q     <= in_s;
      in_p     <= in_q;
      kb_row_q <= keyboard_row;
    end
  end

  // State register, game datapath and registered outputs; power-off acts as reset.
  always_ff @(posedge clk) begin
    if (!rst_n || !sw_power) begin
      state_q <= S_OFF;        board_q <= '0;           turn_q <= 1'b0;
      winner_q <= 1'b0;        memrst_done_q <= 1'b0;   clr_q <= 6'd0;
      x_q <= 3'd0;             y_q <= 3'd0;             x_valid_q <= 1'b0;
      y_valid_q <= 1'b0;       last_x_q <= 3'd0;        last_y_q <= 3'd0;
      kb_c_q <= 2'd0;          kb_idle_q <= 2'd0;       kb_lock_q <= 1'b0;
      ry_q <= 3'd7;            beep_cnt_q <= 32'd0;     tone_sel_q <= 1'b0;
      buzzer_out_q <= 1'b0;    led_red_status_q <= 1'b0; led_green_status_q <= 1'b0;
      led_row_q <= 8'hFF;      led_col_red_q <= 8'h00;  led_col_green_q <= 8'h00;
      keyboard_col_q <= 4'b0111;
    end else begin
      state_q <= state_d;
      if (rise_s[4]) begin
        kb_c_q         <= kb_c_q + 2'd1;
        keyboard_col_q <= ~(4'b1000 >> (kb_c_q + 2'd1));
        if (key_any_s) begin
          kb_lock_q <= 1'b1;
          kb_idle_q <= 2'd0;
        end else if (kb_idle_q == 2'd3) begin
          kb_lock_q <= 1'b0;
        end else begin
          kb_idle_q <= kb_idle_q + 2'd1;
        end
      end
      if (rise_s[5]) begin
        ry_q      <= ry_q + 3'd1;
        led_row_q <= ~(8'h01 << (ry_q + 3'd1));
      end
      if (beep_cnt_q != 32'd0) beep_cnt_q <= beep_cnt_q - 32'd1;
      case (state_q)
        S_CLEAR: begin
          board_q[clr_q] <= CELL_EMPTY;
          clr_q          <= clr_q + 6'd1;
          if (clr_q == 6'd63) memrst_done_q <= 1'b1;
        end
        S_PLAY: begin
          if (press_s) begin
            if (key_row_s[1]) begin
              x_q <= {key_row_s[0], kb_c_q};
              x_valid_q <= 1'b1;
            end else begin
              y_q <= {key_row_s[0], kb_c_q};
              y_valid_q <= 1'b1;
            end
          end
          if (commit_s) begin
            x_valid_q <= 1'b0;
            y_valid_q <= 1'b0;
            if (occupied_s) begin
              beep_cnt_q <= 32'(ERR_LEN);
              tone_sel_q <= 1'b1;
            end else begin
              board_q[{y_q, x_q}] <= colour_s;
              last_x_q   <= x_q;
              last_y_q   <= y_q;
              beep_cnt_q <= 32'(BEEP_LEN);
              tone_sel_q <= 1'b0;
            end
          end
        end
        S_CHECK: begin
          if (!rst_rise_s && win_s) begin
            winner_q   <= turn_q;
            beep_cnt_q <= 32'(WIN_LEN);
            tone_sel_q <= 1'b1;
          end else if (!rst_rise_s) begin
            turn_q <= !turn_q;
          end
        end
        default: ;
      endcase
      if (rst_rise_s && (state_q == S_PLAY || state_q == S_CHECK || state_q == S_WIN)) begin
        memrst_done_q <= 1'b0;
        clr_q         <= 6'd0;
        turn_q        <= 1'b0;
        winner_q      <= 1'b0;
        x_valid_q     <= 1'b0;
        y_valid_q     <= 1'b0;
      end
      buzzer_out_q       <= (beep_cnt_q != 32'd0) && (tone_sel_q ? in_q[6] : in_q[7]);
      led_red_status_q   <= stat_red_s;
      led_green_status_q <= stat_green_s;
      led_col_red_q      <= col_red_s;
      led_col_green_q    <= col_green_s;
    end
  end

  assign buzzer_out       = buzzer_out_q;
  assign led_red_status   = led_red_status_q;
  assign led_green_status = led_green_status_q;
  assign led_row          = led_row_q;
  assign led_col_red      = led_col_red_q;
  assign led_col_green    = led_col_green_q;
  assign keyboard_col     = keyboard_col_q;

endmodule

// File: tb/tb_gomoku_main.sv
// Directed bench for gomoku_main: power-up, key entry, commits, win and restart.
module tb_gomoku_main;
  localparam int BEEP_LEN = 20;
  localparam int ERR_LEN  = 40;
  localparam int WIN_LEN  = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic buzzer_clk = 1'b0, buzzer_clk_2 = 1'b0, led_scan_clk = 1'b0, kb_scan_clk = 1'b0;
  logic led_flicker_clk_slow = 1'b0, led_flicker_clk_fast = 1'b0;
  logic sw_power = 1'b0, btn_reset = 1'b0, btn_ok = 1'b0;
  logic buzzer_out, led_red_status, led_green_status;
  logic [7:0] led_row, led_col_red, led_col_green;
  logic [3:0] keyboard_row, keyboard_col;

  logic       key_on = 1'b0;
  logic [1:0] kr = 2'd0, kc = 2'd0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Key matrix model: held key (kr,kc) pulls row bit (3-kr) low while column (3-kc) is driven low.
  assign keyboard_row = (key_on && keyboard_col[2'd3 - kc] == 1'b0) ? ~(4'b1000 >> kr) : 4'hF;

  gomoku_main #(.BEEP_LEN(BEEP_LEN), .ERR_LEN(ERR_LEN), .WIN_LEN(WIN_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .buzzer_clk(buzzer_clk), .buzzer_clk_2(buzzer_clk_2),
    .led_scan_clk(led_scan_clk), .kb_scan_clk(kb_scan_clk),
    .led_flicker_clk_slow(led_flicker_clk_slow), .led_flicker_clk_fast(led_flicker_clk_fast),
    .sw_power(sw_power), .btn_reset(btn_reset), .btn_ok(btn_ok),
    .buzzer_out(buzzer_out), .led_red_status(led_red_status), .led_green_status(led_green_status),
    .led_row(led_row), .led_col_red(led_col_red), .led_col_green(led_col_green),
    .keyboard_row(keyboard_row), .keyboard_col(keyboard_col));

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic kb_pulse();
    kb_scan_clk = 1'b1; wait_clk(3);
    kb_scan_clk = 1'b0; wait_clk(3);
  endtask

  task automatic press_key(input logic [3:0] code);
    kr = code[3:2]; kc = code[1:0]; key_on = 1'b1;
    repeat (4) kb_pulse();
    key_on = 1'b0;
    repeat (5) kb_pulse();
  endtask

  task automatic pulse_ok();
    btn_ok = 1'b1; wait_clk(3);
    btn_ok = 1'b0; wait_clk(3);
  endtask

  task automatic do_move(input logic [2:0] x, input logic [2:0] y);
    press_key({1'b1, x});
    press_key({1'b0, y});
    pulse_ok();
    wait_clk(4);
  endtask

  // Advance the LED scan until row y is selected, then return the column data.
  task automatic read_row(input logic [2:0] y, output logic [7:0] red, output logic [7:0] green);
    logic [7:0] target;
    target = ~(8'h01 << y);
    for (int i = 0; i < 12 && led_row !== target; i++) begin
      led_scan_clk = 1'b1; wait_clk(3);
      led_scan_clk = 1'b0; wait_clk(3);
    end
    total++;
    if (led_row !== target) begin
      bad++;
      $display("FAIL row_select: got %h want %h", led_row, target);
    end
    red = led_col_red; green = led_col_green;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw_power = 1'b0; wait_clk(4);
    total++; if (led_row !== 8'hFF) begin bad++; $display("FAIL reset_led_row: got %h want ff", led_row); end
    total++; if (led_col_red !== 8'h00 || led_col_green !== 8'h00) begin bad++; $display("FAIL reset_cols: got %h/%h want 00/00", led_col_red, led_col_green); end
    total++; if (led_red_status !== 1'b0 || led_green_status !== 1'b0) begin bad++; $display("FAIL reset_status: got %b%b want 00", led_red_status, led_green_status); end
    total++; if (buzzer_out !== 1'b0) begin bad++; $display("FAIL reset_buzzer: got %b want 0", buzzer_out); end
    total++; if (keyboard_col !== 4'b0111) begin bad++; $display("FAIL reset_kbcol: got %b want 0111", keyboard_col); end
    rst_n = 1'b1; wait_clk(3);
    total++; if (led_red_status !== 1'b0 || dut.state_q !== 3'd0) begin bad++; $display("FAIL power_off_hold: got %b st=%0d want 0 st=0", led_red_status, dut.state_q); end
  endtask

  task automatic test_powerup();
    int n;
    sw_power = 1'b1;
    n = 0;
    while (dut.memrst_done_q !== 1'b1 && n < 80) begin wait_clk(1); n++; end
    total++; if (n > 67) begin bad++; $display("FAIL memrst_time: got %0d cycles want <=67", n); end
    wait_clk(2);
    total++; if (led_red_status !== 1'b1 || led_green_status !== 1'b0) begin bad++; $display("FAIL powerup_status: got %b%b want 10", led_red_status, led_green_status); end
    total++; if (dut.board_q !== 128'd0) begin bad++; $display("FAIL powerup_board: got %h want 0", dut.board_q); end
  endtask

  task automatic test_key_commit();
    logic [7:0] r, g;
    press_key(4'd15);
    total++; if (dut.x_q !== 3'd7 || dut.x_valid_q !== 1'b1) begin bad++; $display("FAIL key_x: got %0d/%b want 7/1", dut.x_q, dut.x_valid_q); end
    press_key(4'd2);
    total++; if (dut.y_q !== 3'd2 || dut.y_valid_q !== 1'b1) begin bad++; $display("FAIL key_y: got %0d/%b want 2/1", dut.y_q, dut.y_valid_q); end
    buzzer_clk = 1'b1; buzzer_clk_2 = 1'b0;
    btn_ok = 1'b1; wait_clk(3);
    total++; if (buzzer_out !== 1'b1) begin bad++; $display("FAIL confirm_beep_on: got %b want 1", buzzer_out); end
    buzzer_clk = 1'b0; buzzer_clk_2 = 1'b1; wait_clk(3);
    total++; if (buzzer_out !== 1'b0) begin bad++; $display("FAIL confirm_beep_tone: got %b want 0", buzzer_out); end
    btn_ok = 1'b0; buzzer_clk = 1'b1; wait_clk(BEEP_LEN + 2);
    total++; if (buzzer_out !== 1'b0) begin bad++; $display("FAIL confirm_beep_len: got %b want 0", buzzer_out); end
    total++; if (dut.board_q[23] !== 2'd1) begin bad++; $display("FAIL cell_7_2: got %0d want 1", dut.board_q[23]); end
    total++; if (led_red_status !== 1'b0 || led_green_status !== 1'b1) begin bad++; $display("FAIL turn_green: got %b%b want 01", led_red_status, led_green_status); end
    read_row(3'd2, r, g);
    total++; if (r !== 8'h80 || g !== 8'h00) begin bad++; $display("FAIL row2_cols: got %h/%h want 80/00", r, g); end
    buzzer_clk = 1'b0; buzzer_clk_2 = 1'b0;
  endtask

  task automatic test_occupied();
    press_key(4'd15); press_key(4'd2);
    buzzer_clk = 1'b0; buzzer_clk_2 = 1'b1;
    btn_ok = 1'b1; wait_clk(3);
    total++; if (buzzer_out !== 1'b1) begin bad++; $display("FAIL err_beep_on: got %b want 1", buzzer_out); end
    btn_ok = 1'b0; wait_clk(BEEP_LEN + 5);
    total++; if (buzzer_out !== 1'b1) begin bad++; $display("FAIL err_beep_hold: got %b want 1", buzzer_out); end
    wait_clk(ERR_LEN - BEEP_LEN);
    total++; if (buzzer_out !== 1'b0) begin bad++; $display("FAIL err_beep_len: got %b want 0", buzzer_out); end
    total++; if (dut.board_q[23] !== 2'd1) begin bad++; $display("FAIL occupied_cell: got %0d want 1", dut.board_q[23]); end
    total++; if (led_green_status !== 1'b1 || dut.x_valid_q !== 1'b0) begin bad++; $display("FAIL occupied_turn_sel: got %b/%b want 1/0", led_green_status, dut.x_valid_q); end
  endtask

  task automatic test_incomplete();
    logic [127:0] snap;
    snap = 128'd0;
    snap[47:46] = 2'd1;
    press_key(4'd15);
    buzzer_clk = 1'b1; buzzer_clk_2 = 1'b1;
    pulse_ok(); wait_clk(4);
    total++; if (buzzer_out !== 1'b0) begin bad++; $display("FAIL incomplete_beep: got %b want 0", buzzer_out); end
    total++; if (dut.board_q !== snap) begin bad++; $display("FAIL incomplete_board: got %h want %h", dut.board_q, snap); end
    total++; if (led_green_status !== 1'b1) begin bad++; $display("FAIL incomplete_turn: got %b want 1", led_green_status); end
    buzzer_clk = 1'b0; buzzer_clk_2 = 1'b0;
  endtask

  task automatic test_vertical_win();
    do_move(3'd0, 3'd0); do_move(3'd7, 3'd3);
    do_move(3'd0, 3'd1); do_move(3'd7, 3'd4);
    do_move(3'd0, 3'd2); do_move(3'd7, 3'd5);
    total++; if (dut.state_q !== 3'd2 || led_green_status !== 1'b1) begin bad++; $display("FAIL four_no_win: got st=%0d g=%b want st=2 g=1", dut.state_q, led_green_status); end
    do_move(3'd0, 3'd3);
    buzzer_clk_2 = 1'b1;
    do_move(3'd7, 3'd6);
    total++; if (dut.state_q !== 3'd4) begin bad++; $display("FAIL win_state: got %0d want 4", dut.state_q); end
    total++; if (buzzer_out !== 1'b1) begin bad++; $display("FAIL win_beep: got %b want 1", buzzer_out); end
    led_flicker_clk_fast = 1'b1; wait_clk(3);
    total++; if (led_red_status !== 1'b1 || led_green_status !== 1'b0) begin bad++; $display("FAIL win_blink_hi: got %b%b want 10", led_red_status, led_green_status); end
    led_flicker_clk_fast = 1'b0; wait_clk(3);
    total++; if (led_red_status !== 1'b0 || led_green_status !== 1'b0) begin bad++; $display("FAIL win_blink_lo: got %b%b want 00", led_red_status, led_green_status); end
    buzzer_clk_2 = 1'b0;
    do_move(3'd1, 3'd0);
    total++; if (dut.board_q[1] !== 2'd0 || dut.x_valid_q !== 1'b0) begin bad++; $display("FAIL win_keys_ignored: got %0d/%b want 0/0", dut.board_q[1], dut.x_valid_q); end
  endtask

  task automatic test_reset_in_win();
    logic [7:0] r, g;
    btn_reset = 1'b1; wait_clk(3);
    btn_reset = 1'b0; wait_clk(70);
    total++; if (dut.board_q !== 128'd0 || dut.memrst_done_q !== 1'b1) begin bad++; $display("FAIL restart_board: got %h/%b want 0/1", dut.board_q, dut.memrst_done_q); end
    total++; if (led_red_status !== 1'b1 || led_green_status !== 1'b0) begin bad++; $display("FAIL restart_turn: got %b%b want 10", led_red_status, led_green_status); end
    read_row(3'd6, r, g);
    total++; if (r !== 8'h00 || g !== 8'h00) begin bad++; $display("FAIL restart_row6: got %h/%h want 00/00", r, g); end
    read_row(3'd0, r, g);
    total++; if (r !== 8'h00 || g !== 8'h00) begin bad++; $display("FAIL restart_row0: got %h/%h want 00/00", r, g); end
  endtask

  task automatic test_power_off();
    sw_power = 1'b0; wait_clk(2);
    total++; if (led_row !== 8'hFF || led_red_status !== 1'b0 || keyboard_col !== 4'b0111) begin bad++; $display("FAIL power_off: got %h/%b/%b want ff/0/0111", led_row, led_red_status, keyboard_col); end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_key_commit();
    test_occupied();
    test_incomplete();
    test_vertical_win();
    test_reset_in_win();
    test_power_off();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
